// File: rtl/umi_demux_reg.sv
// Single-stage registered UMI demultiplexer: one request stream is captured
// in an output register and presented to exactly one of N output ports.
module umi_demux_reg #(
  parameter int N  = 4,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi_in_valid,
  input  logic [N-1:0]  umi_in_select,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic [N-1:0]  umi_out_valid,
  input  logic [N-1:0]  umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  output logic          umi_drop
);

  logic         full_p0;
  logic [N-1:0] sel_p0;
  logic [N-1:0] sel_d;
  logic         drain;
  logic         accept;

  // Lowest set select bit wins when upstream presents a multi-hot select.
  always_comb begin
    logic seen;
    seen  = 1'b0;
    sel_d = '0;
    for (int j = 0; j < N; j++) begin
      sel_d[j] = umi_in_select[j] & ~seen;
      seen     = seen | umi_in_select[j];
    end
  end

  assign drain         = full_p0 & |(sel_p0 & umi_out_ready);
  assign umi_in_ready  = ~full_p0 | drain;
  assign accept        = umi_in_valid & umi_in_ready;
  assign umi_out_valid = full_p0 ? sel_p0 : '0;

  // Stage p0: output register holding the packet and its destination.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_p0         <= 1'b0;
      sel_p0          <= '0;
      umi_drop        <= 1'b0;
      umi_out_cmd     <= '0;
      umi_out_dstaddr <= '0;
      umi_out_srcaddr <= '0;
      umi_out_data    <= '0;
    end else begin
      umi_drop <= 1'b0;
      if (accept && |sel_d) begin
        full_p0         <= 1'b1;
        sel_p0          <= sel_d;
        umi_out_cmd     <= umi_in_cmd;
        umi_out_dstaddr <= umi_in_dstaddr;
        umi_out_srcaddr <= umi_in_srcaddr;
        umi_out_data    <= umi_in_data;
      end else if (accept) begin
        // No destination: the packet is swallowed and flagged.
        umi_drop <= 1'b1;
        if (drain) begin
          full_p0 <= 1'b0;
          sel_p0  <= '0;
        end
      end else if (drain) begin
        full_p0 <= 1'b0;
        sel_p0  <= '0;
      end
    end
  end

endmodule
